tick_wave_gen: RTL

Waveform stage fed by the modulo-N tick divider. Advances a phase accumulator by a programmable step on every divider tick and produces a registered sample plus valid strobe. Shape is saw, square, triangle or inverted saw. Step/mode updates are double-buffered and applied only at a phase wrap, so output frequency changes are glitch-free. Sample output feeds the DAC/output formatter.

---
 rtl/tick_wave_gen_pkg.sv | 18 +
 rtl/tick_wave_gen_shaper.sv | 37 +++
 rtl/tick_wave_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tick_wave_gen_pkg.sv
// Shared encodings for the tick-driven waveform generator.
package tick_wave_gen_pkg;

  // Output shape selection, as written through mode_in.
  typedef enum logic [1:0] {
    MODE_SAW  = 2'd0,
    MODE_SQR  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_ISAW = 2'd3
  } mode_t;

  // Controller states: IDLE until the first configuration is taken, then RUN.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tick_wave_gen_shaper.sv
// Combinational phase-to-sample shaping; the parent registers the result.
module wave_shaper
  import tick_wave_gen_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         mode,
  output logic [OUT_W-1:0]   sample
);

  logic             msb;
  logic [OUT_W-1:0] saw;
  logic [OUT_W-1:0] tri_t;
  logic             unused_phase_bits;

  assign msb   = phase[PHASE_W-1];
  assign saw   = phase[PHASE_W-1 -: OUT_W];
  assign tri_t = phase[PHASE_W-2 -: OUT_W];

  // The low phase bits only provide fractional resolution and never reach the sample.
  assign unused_phase_bits = ^phase;

  // Select the shape; the triangle folds the second half of the cycle downwards.
  always_comb begin
    sample = '0;
    case (mode_t'(mode))
      MODE_SAW:  sample = saw;
      MODE_SQR:  sample = msb ? '0 : '1;
      MODE_TRI:  sample = msb ? ~tri_t : tri_t;
      MODE_ISAW: sample = ~saw;
      default:   sample = '0;
    endcase
  end

endmodule

// File: rtl/tick_wave_gen.sv
// Phase-accumulator waveform generator advanced by divider ticks. Step and
// mode changes are staged in a shadow register and only take effect at a
// phase wrap (or immediately while the step is zero), keeping frequency
// changes glitch-free.
module tick_wave_gen
  import tick_wave_gen_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [PHASE_W-1:0] step_in,
  input  logic [1:0]         mode_in,
  input  logic               step_load,
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid,
  output logic               wrap,
  output logic               busy
);

  state_t             state;
  state_t             state_nxt;

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] act_step;
  logic [1:0]         act_mode;
  logic [PHASE_W-1:0] pend_step;
  logic [1:0]         pend_mode;
  logic               pend_valid;

  logic [PHASE_W:0]   sum;
  logic               carry;
  logic [PHASE_W-1:0] new_phase;
  logic [OUT_W-1:0]   shaped;

  logic               enter_run;
  logic               run_tick;
  logic               apply_cfg;

  assign sum       = {1'b0, phase} + {1'b0, act_step};
  assign carry     = sum[PHASE_W];
  assign new_phase = sum[PHASE_W-1:0];

  // Shape is computed from the advanced phase with the currently active mode,
  // so an applying tick still emits a sample built from the old config.
  wave_shaper #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_shaper (
    .phase  (new_phase),
    .mode   (act_mode),
    .sample (shaped)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic plus per-cycle control strobes for the datapath.
  always_comb begin
    state_nxt = state;
    enter_run = 1'b0;
    run_tick  = 1'b0;
    apply_cfg = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && pend_valid) begin
          state_nxt = ST_RUN;
          enter_run = 1'b1;
          apply_cfg = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          run_tick = 1'b1;
          if (carry || (act_step == '0)) apply_cfg = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase, sample registers and the shadow/active configuration pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase        <= '0;
      act_step     <= '0;
      act_mode     <= '0;
      pend_step    <= '0;
      pend_mode    <= '0;
      pend_valid   <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      wrap         <= 1'b0;

      if (enter_run) phase <= '0;

      if (run_tick) begin
        phase        <= new_phase;
        sample       <= shaped;
        sample_valid <= 1'b1;
        wrap         <= carry;
      end

      if (apply_cfg) begin
        if (step_load) begin
          act_step   <= step_in;
          act_mode   <= mode_in;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          act_step   <= pend_step;
          act_mode   <= pend_mode;
          pend_valid <= 1'b0;
        end
      end else if (step_load) begin
        pend_step  <= step_in;
        pend_mode  <= mode_in;
        pend_valid <= 1'b1;
      end
    end
  end

  assign busy = pend_valid;

endmodule
